// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-requester RAM arbiter: FSM states, grant codes
// and the winner-selection rule used at arbitration time.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_PRG = 1'b1
    } gnt_t;

    localparam int NUM_REQ      = 2;
    localparam int STARVE_CTR_W = 4;

    // CPU has priority unless the loader is alone or has been starved long enough.
    function automatic gnt_t pick_winner(input logic cpu_req, input logic prg_req,
                                         input logic force_prg);
        if (prg_req && (!cpu_req || force_prg)) begin
            return GNT_PRG;
        end
        return GNT_CPU;
    endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of arbitrations the program loader lost to the CPU; only
// built when RAM_ARB_FAIRNESS_EN is defined.
module ram_arb_starve_ctr
    import ram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_valid,
    input  logic grant_prg,
    input  logic prg_req,
    output logic force_prg
);

    localparam logic [STARVE_CTR_W-1:0] LIMIT = STARVE_CTR_W'(STARVE_LIMIT);

    logic [STARVE_CTR_W-1:0] cnt_reg;
    logic [STARVE_CTR_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (grant_valid) begin
            if (grant_prg) begin
                cnt_next = '0;
            end else if (prg_req && (cnt_reg != LIMIT)) begin
                cnt_next = cnt_reg + STARVE_CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_prg = (cnt_reg == LIMIT);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates CPU and program-loader access to a single-port async RAM with a
// four-cycle IDLE/ADDR/DATA/ACK handshake. RAM_ARB_FAIRNESS_EN adds anti-starvation.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              prg_req,
    input  logic              prg_we,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [DATA_W-1:0] prg_wdata,
    output logic              prg_ack,
    output logic [DATA_W-1:0] prg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("ram_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t state_reg;
    state_t state_next;
    gnt_t   gnt_reg;
    gnt_t   gnt_next;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] we_vec;
    logic [ADDR_W-1:0]  addr_vec  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_vec [NUM_REQ];
    logic [DATA_W-1:0]  rdata_reg [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [NUM_REQ-1:0] ack_vec;

    logic arb_fire;
    logic force_prg;

    // Requester ports gathered into vectors indexed by grant code.
    assign req_vec      = {prg_req, cpu_req};
    assign we_vec       = {prg_we, cpu_we};
    assign addr_vec[0]  = cpu_addr;
    assign addr_vec[1]  = prg_addr;
    assign wdata_vec[0] = cpu_wdata;
    assign wdata_vec[1] = prg_wdata;

    assign arb_fire = (state_reg == IDLE) && (|req_vec);
    assign gnt_next = pick_winner(cpu_req, prg_req, force_prg);

`ifdef RAM_ARB_FAIRNESS_EN
    ram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .grant_valid (arb_fire),
        .grant_prg   (gnt_next == GNT_PRG),
        .prg_req     (prg_req),
        .force_prg   (force_prg)
    );
`else
    assign force_prg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_vec) state_next = ADDR;
            ADDR:    state_next = DATA;
            DATA:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The winner's request is frozen here so later input changes cannot disturb the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg   <= GNT_CPU;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (arb_fire) begin
            gnt_reg   <= gnt_next;
            we_reg    <= we_vec[gnt_next];
            addr_reg  <= addr_vec[gnt_next];
            wdata_reg <= wdata_vec[gnt_next];
        end
    end

    always_comb begin
        gnt_onehot = (gnt_reg == GNT_PRG) ? 2'b10 : 2'b01;
        ack_vec    = '0;
        ram_ce_n   = 1'b1;
        ram_we_n   = 1'b1;
        busy       = (state_reg != IDLE);
        if (state_reg == DATA) begin
            ram_ce_n = 1'b0;
            ram_we_n = ~we_reg;
        end
        if (state_reg == ACK) begin
            ack_vec = gnt_onehot;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rdata
            // Read data is captured at the end of DATA and held until this requester's next read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if ((state_reg == DATA) && !we_reg && gnt_onehot[gi]) begin
                    rdata_reg[gi] <= ram_rdata;
                end
            end
        end
    endgenerate

    assign cpu_ack   = ack_vec[0];
    assign prg_ack   = ack_vec[1];
    assign cpu_rdata = rdata_reg[0];
    assign prg_rdata = rdata_reg[1];
    assign ram_addr  = addr_reg;
    assign ram_wdata = wdata_reg;

endmodule
